// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared definitions for the serial receive path: the default
//               bit period, the data width and the receiver state encoding.
//               Imported by the receiver, its bus interface and the bench.
// Contents    : CLKS_PER_BIT_DEFAULT, DATA_BITS, uart_rx_state_e,
//               mid_bit_count()
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // 100 MHz system clock / 115200 baud.
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

  // 8N1 framing: eight data bits, LSB first.
  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

  // Counter value at which the start bit is re-checked. Integer division
  // puts the sample at (or just before) the middle of the bit, so every
  // later sample, one full period apart, also lands near mid-bit.
  function automatic int unsigned mid_bit_count(input int unsigned clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Receive-side bus carrying a byte and its status strobes to
//               the downstream register.
// Signals     : rx_data   - last correctly received byte (register wdata)
//               rx_valid  - one-cycle strobe, rx_data updated (register we)
//               frame_err - one-cycle strobe, stop bit sampled low
//               busy      - receiver is inside a frame
// Modports    : master - driven by the receiver
//               slave  - observed by the consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;

  modport master (
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    input rx_data,
    input rx_valid,
    input frame_err,
    input busy
  );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous input.
//               Output lags the input by two clk cycles. The reset value is
//               a parameter so idle-high lines come out of reset idle.
// Ports       : clk      - destination clock
//               reset_n  - asynchronous active-low reset
//               i_d      - asynchronous input
//               o_q      - synchronized output
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver. The line is synchronized, a falling edge
//               starts a frame, the start bit is re-checked at mid-bit, and
//               each data bit and the stop bit are sampled one bit period
//               apart. A good stop bit loads rx_data and strobes rx_valid; a
//               low stop bit strobes frame_err and leaves rx_data untouched.
// Ports       : clk       - system clock
//               reset_n   - asynchronous active-low reset
//               rx        - asynchronous serial line, idle high
//               rx_data   - last correctly received byte
//               rx_valid  - one-cycle strobe, rx_data updated
//               frame_err - one-cycle strobe, stop bit sampled low
//               busy      - high whenever the receiver is not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned      CNT_W      = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_MID_CNT  = CNT_W'(mid_bit_count(CLKS_PER_BIT));
  localparam logic [2:0]       c_LAST_BIT = 3'(DATA_BITS - 1);

  logic                 w_rx_s;

  uart_rx_state_e       r_state;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_frame_err;
  // Cleared by a framing error so a held-low line (break) is reported once;
  // the line must return high before another start is accepted.
  logic                 r_armed;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     (rx),
    .o_q     (w_rx_s)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_armed     <= 1'b1;
    end else begin
      // Strobes are single-cycle unless the stop sample re-asserts them.
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      case (r_state)
        IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (!r_armed) begin
            if (w_rx_s) begin
              r_armed <= 1'b1;
            end
          end else if (!w_rx_s) begin
            r_state <= START;
          end
        end

        START: begin
          if (r_clk_cnt == c_MID_CNT) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            // Line back high at mid-bit: treat as noise, not a frame.
            r_state   <= w_rx_s ? IDLE : DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (r_clk_cnt == c_LAST_CNT) begin
            r_shift[r_bit_idx] <= w_rx_s;
            r_clk_cnt          <= '0;
            if (r_bit_idx == c_LAST_BIT) begin
              r_state <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (r_clk_cnt == c_LAST_CNT) begin
            r_clk_cnt <= '0;
            r_state   <= IDLE;
            if (w_rx_s) begin
              r_rx_data  <= r_shift;
              r_rx_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              r_armed     <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire
